ads_chan_scheduler: RTL and testbench

Round-robin scheduler that shares one output port among the four decimated ADS channels. It sits downstream of the per-channel decimator and accepts each channel's held sample word plus its output-enable strobe. It buffers one pending sample per channel and serialises pending samples onto a single valid/ready stream tagged with the channel number, for the packet or UART framer. Overwrite events are recorded in sticky per-channel flags.

---
 rtl/ads_chan_scheduler.sv | 113 +++++++++++
 tb/tb_ads_chan_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ads_chan_scheduler.sv
// Round-robin scheduler serialising one pending sample per ADS channel onto a
// single valid/ready stream tagged with the channel id; sticky overrun flags.
module ads_chan_scheduler #(
    parameter int NCH = 4,
    parameter int DW  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] ch_data,
    input  logic [NCH-1:0]    ch_strobe,
    input  logic [NCH-1:0]    ch_enable,
    input  logic              ovr_clr,
    output logic [DW-1:0]     dout,
    output logic [1:0]        dout_ch,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [NCH-1:0]    overrun
);

    logic [NCH-1:0]         r_s0, r_s1, r_s2;
    logic [NCH-1:0]         r_pending;
    logic [NCH-1:0][DW-1:0] r_hold;
    logic [NCH-1:0]         r_overrun;
    logic [1:0]             r_last;
    logic [DW-1:0]          r_dout;
    logic [1:0]             r_dout_ch;
    logic                   r_dout_valid;

    logic [NCH-1:0]         w_edge;
    logic [NCH-1:0]         w_qual;
    logic [NCH-1:0]         w_ovr_set;
    logic                   w_free;
    logic                   w_gnt_vld;
    logic [1:0]             w_gnt;
    logic [1:0]             w_idx;

    assign w_edge = r_s1 & ~r_s2;
    assign w_qual = r_pending & ch_enable;
    assign w_free = ~r_dout_valid | dout_ready;

    // Search order last+1 .. last+4 (mod 4); the first qualifying channel wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_idx     = '0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            w_idx = r_last + 2'(i);
            if (!w_gnt_vld && w_qual[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = w_idx;
            end
        end
        w_gnt_vld = w_gnt_vld & w_free;
    end

    // A grant in the same cycle consumes the old sample, so it is not an overrun.
    always_comb begin
        w_ovr_set = '0;
        for (int unsigned n = 0; n < NCH; n++) begin
            w_ovr_set[n] = ch_enable[n] & w_edge[n] & r_pending[n]
                         & ~(w_gnt_vld & (w_gnt == 2'(n)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0         <= '0;
            r_s1         <= '0;
            r_s2         <= '0;
            r_pending    <= '0;
            r_hold       <= '0;
            r_overrun    <= '0;
            r_last       <= 2'd3;
            r_dout       <= '0;
            r_dout_ch    <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_s0 <= ch_strobe;
            r_s1 <= r_s0;
            r_s2 <= r_s1;

            for (int unsigned n = 0; n < NCH; n++) begin
                if (!ch_enable[n]) begin
                    r_pending[n] <= 1'b0;
                end else if (w_edge[n]) begin
                    r_pending[n] <= 1'b1;
                    r_hold[n]    <= ch_data[n*DW +: DW];
                end else if (w_gnt_vld && (w_gnt == 2'(n))) begin
                    r_pending[n] <= 1'b0;
                end
            end

            r_overrun <= w_ovr_set | (r_overrun & ~{NCH{ovr_clr}});

            if (w_free) begin
                if (w_gnt_vld) begin
                    r_dout       <= r_hold[w_gnt];
                    r_dout_ch    <= w_gnt;
                    r_dout_valid <= 1'b1;
                    r_last       <= w_gnt;
                end else begin
                    r_dout_valid <= 1'b0;
                end
            end
        end
    end

    assign dout       = r_dout;
    assign dout_ch    = r_dout_ch;
    assign dout_valid = r_dout_valid;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_ads_chan_scheduler.sv
// Directed self-checking bench for ads_chan_scheduler with hand-computed expectations.
module tb_ads_chan_scheduler;

    logic        clk;
    logic        rst;
    logic [63:0] ch_data;
    logic [3:0]  ch_strobe;
    logic [3:0]  ch_enable;
    logic        ovr_clr;
    logic [15:0] dout;
    logic [1:0]  dout_ch;
    logic        dout_valid;
    logic        dout_ready;
    logic [3:0]  overrun;

    int n_tests;
    int n_fail;
    int vcnt;
    logic [15:0] last_d;
    logic [1:0]  last_c;

    ads_chan_scheduler #(.NCH(4), .DW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_data    (ch_data),
        .ch_strobe  (ch_strobe),
        .ch_enable  (ch_enable),
        .ovr_clr    (ovr_clr),
        .dout       (dout),
        .dout_ch    (dout_ch),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe; data held until the capture edge two cycles later.
    task automatic pulse(input int n, input logic [15:0] d);
        ch_data[n*16 +: 16] = d;
        ch_strobe[n] = 1'b1;
        tick();
        ch_strobe[n] = 1'b0;
        tick();
        tick();
    endtask

    task automatic settle();
        ch_strobe = '0;
        repeat (3) tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; ch_data = '0; ch_strobe = '0; ch_enable = 4'hF;
        ovr_clr = 1'b0; dout_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_ch", 32'(dout_ch), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);

        // Single sample on channel 2, strobe high for 5 cycles
        ch_data[32 +: 16] = 16'h1234;
        ch_strobe[2] = 1'b1;
        vcnt = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 5) ch_strobe[2] = 1'b0;
            if (i == 3) check("single_lat_early", 32'(dout_valid), 32'd0);
            if (i == 4) begin
                check("single_valid", 32'(dout_valid), 32'd1);
                check("single_dout", 32'(dout), 32'h1234);
                check("single_ch", 32'(dout_ch), 32'd2);
            end
            if (dout_valid) vcnt++;
        end
        check("single_count", 32'(vcnt), 32'd1);
        check("single_ovr", 32'(overrun), 32'd0);

        // Fairness from reset: order 0,1,2,3
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        for (int n = 0; n < 4; n++) ch_data[n*16 +: 16] = 16'hA000 + 16'(n);
        ch_strobe = 4'hF;
        tick(); tick(); tick();
        check("fair_early", 32'(dout_valid), 32'd0);
        for (int n = 0; n < 4; n++) begin
            tick();
            check("fair0_valid", 32'(dout_valid), 32'd1);
            check("fair0_ch", 32'(dout_ch), 32'(n));
            check("fair0_dout", 32'(dout), 32'hA000 + 32'(n));
        end
        tick();
        check("fair0_idle", 32'(dout_valid), 32'd0);
        settle();

        // Move last to 1, then all four -> 2,3,0,1
        pulse(1, 16'hB001);
        tick();
        check("last1_dout", 32'(dout), 32'hB001);
        check("last1_ch", 32'(dout_ch), 32'd1);
        tick();
        for (int n = 0; n < 4; n++) ch_data[n*16 +: 16] = 16'hA000 + 16'(n);
        ch_strobe = 4'hF;
        tick(); tick(); tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("fair1_ch", 32'(dout_ch), 32'((k + 2) % 4));
            check("fair1_dout", 32'(dout), 32'hA000 + 32'((k + 2) % 4));
        end
        tick();
        check("fair1_idle", 32'(dout_valid), 32'd0);
        settle();

        // Back-pressure and overrun on channel 0
        dout_ready = 1'b0;
        pulse(0, 16'h0001);
        tick();
        check("bp_valid", 32'(dout_valid), 32'd1);
        check("bp_dout", 32'(dout), 32'h0001);
        pulse(0, 16'h0005);
        check("bp_no_ovr", 32'(overrun), 32'd0);
        pulse(0, 16'h0002);
        check("bp_ovr", 32'(overrun), 32'b0001);
        check("bp_hold_dout", 32'(dout), 32'h0001);
        check("bp_hold_valid", 32'(dout_valid), 32'd1);
        dout_ready = 1'b1;
        tick();
        check("bp_second", 32'(dout), 32'h0002);
        check("bp_second_v", 32'(dout_valid), 32'd1);
        tick();
        check("bp_idle", 32'(dout_valid), 32'd0);
        check("bp_ovr_sticky", 32'(overrun), 32'b0001);
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        check("bp_ovr_clr", 32'(overrun), 32'd0);

        // Same-cycle grant and edge on channel 1
        dout_ready = 1'b0;
        pulse(0, 16'h00AA);
        tick();
        check("sc_busy", 32'(dout), 32'h00AA);
        pulse(1, 16'h1111);
        ch_data[16 +: 16] = 16'h2222;
        ch_strobe[1] = 1'b1;
        tick();
        ch_strobe[1] = 1'b0;
        tick();
        dout_ready = 1'b1;
        tick();
        check("sc_old_dout", 32'(dout), 32'h1111);
        check("sc_old_ch", 32'(dout_ch), 32'd1);
        tick();
        check("sc_new_dout", 32'(dout), 32'h2222);
        check("sc_new_valid", 32'(dout_valid), 32'd1);
        tick();
        check("sc_idle", 32'(dout_valid), 32'd0);
        check("sc_ovr", 32'(overrun), 32'd0);

        // Disabled channel 3 strobing
        ch_enable = 4'b0111;
        pulse(3, 16'h3333);
        vcnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (dout_valid) vcnt++;
        end
        check("dis_count", 32'(vcnt), 32'd0);
        check("dis_ovr", 32'(overrun), 32'd0);
        ch_enable = 4'hF;

        // Channel 3 disabled while pending
        dout_ready = 1'b0;
        pulse(0, 16'h0A0A);
        tick();
        check("dp_busy", 32'(dout), 32'h0A0A);
        pulse(3, 16'h3030);
        ch_enable = 4'b0111;
        tick();
        ch_enable = 4'hF;
        dout_ready = 1'b1;
        tick();
        check("dp_drop0", 32'(dout_valid), 32'd0);
        tick();
        check("dp_drop1", 32'(dout_valid), 32'd0);

        // Reset with a word on the port and an overrun set
        dout_ready = 1'b0;
        pulse(2, 16'h2B2B);
        tick();
        check("rs_valid_pre", 32'(dout_valid), 32'd1);
        pulse(2, 16'h2C2C);
        pulse(2, 16'h2D2D);
        check("rs_ovr_pre", 32'(overrun), 32'b0100);
        ch_data[16 +: 16] = 16'h5A5A;
        ch_strobe[1] = 1'b1;
        rst = 1'b1;
        tick();
        check("rs_valid", 32'(dout_valid), 32'd0);
        check("rs_dout", 32'(dout), 32'd0);
        check("rs_ch", 32'(dout_ch), 32'd0);
        check("rs_ovr", 32'(overrun), 32'd0);
        tick();
        rst = 1'b0;
        dout_ready = 1'b1;
        vcnt = 0; last_d = '0; last_c = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (dout_valid) begin
                vcnt++;
                last_d = dout;
                last_c = dout_ch;
            end
        end
        check("hold_rst_count", 32'(vcnt), 32'd1);
        check("hold_rst_dout", 32'(last_d), 32'h5A5A);
        check("hold_rst_ch", 32'(last_c), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
